// File: rtl/history_sram_arbiter.sv
// Arbitrates the single-port colour-history SRAM between the pixel reader, the detector write-back FIFO
// and the frame-clear sweep. Define HIST_ARB_STATS_EN to build the saturating dropped-write counter.
module history_sram_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_PIXELS = 307200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    output logic              wr_drop,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_we,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [15:0]       stat_drop_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {ST_RUN, ST_CLEAR} state_e;

    // A read in flight: where to look, and whether the SRAM answer is overridden.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              byp;
        logic [DATA_W-1:0] bdata;
    } rd_stage_t;

    state_e state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic clr_done_q, clr_done_d;

    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] fifo_addr_q, fifo_addr_d;
    logic [FIFO_DEPTH-1:0][DATA_W-1:0] fifo_data_q, fifo_data_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] cnt_q, cnt_d;

    logic [1:0] rd_vld_pipe_q, rd_vld_pipe_d;
    rd_stage_t s1_q, s1_d, s2_q, s2_d;

    logic rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic wr_full_q, wr_full_d;
    logic wr_drop_q, wr_drop_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic sram_we_q, sram_we_d;
    logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;

    logic push, pop, fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0] idx;

    // Walk oldest to newest so the last match (newest queued write) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if ((PTR_W + 1)'(i) < cnt_q && fifo_addr_q[idx] == rd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data_q[idx];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        clr_done_d   = clr_done_q;
        fifo_addr_d  = fifo_addr_q;
        fifo_data_d  = fifo_data_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        sram_addr_d  = sram_addr_q;
        sram_we_d    = 1'b0;
        sram_wdata_d = sram_wdata_q;
        push         = 1'b0;
        pop          = 1'b0;
        wr_drop_d    = 1'b0;

        if (state_q == ST_RUN) begin
            if (rd_vld_pipe_q[0]) begin
                sram_addr_d = s1_q.addr;
            end else if (cnt_q != '0) begin
                pop          = 1'b1;
                sram_we_d    = 1'b1;
                sram_addr_d  = fifo_addr_q[rd_ptr_q];
                sram_wdata_d = fifo_data_q[rd_ptr_q];
            end
            if (wr_req) begin
                if (cnt_q != FULL_CNT || pop) push = 1'b1;
                else                          wr_drop_d = 1'b1;
            end
            if (clear_start) begin
                state_d    = ST_CLEAR;
                clr_cnt_d  = '0;
                clr_done_d = 1'b0;
            end
        end else begin
            wr_drop_d = wr_req;
            if (!clr_done_q) begin
                sram_we_d    = 1'b1;
                sram_addr_d  = clr_cnt_q;
                sram_wdata_d = '0;
                if (clr_cnt_q == LAST_ADDR) clr_done_d = 1'b1;
                else                        clr_cnt_d  = clr_cnt_q + 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end

        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push) begin
            fifo_addr_d[wr_ptr_q] = wr_addr;
            fifo_data_d[wr_ptr_q] = wr_data;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        // Anything queued (including a push this cycle) is superseded by the clear.
        if (state_q == ST_RUN && clear_start) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
        wr_full_d = (cnt_d == FULL_CNT);
    end

    // Read pipe: capture forwarding at request time, take the slot next cycle, return the cycle after.
    // A read whose slot falls inside a clear also answers 0, since the sweep owns the SRAM.
    always_comb begin
        rd_vld_pipe_d = {rd_vld_pipe_q[0], rd_req};
        s1_d.addr     = rd_addr;
        s1_d.byp      = fwd_hit || state_q == ST_CLEAR;
        s1_d.bdata    = (state_q == ST_CLEAR) ? '0 : fwd_data;
        s2_d.addr     = s1_q.addr;
        s2_d.byp      = s1_q.byp || state_q == ST_CLEAR;
        s2_d.bdata    = (state_q == ST_CLEAR) ? '0 : s1_q.bdata;
        rd_valid_d    = rd_vld_pipe_q[1];
        rd_data_d     = rd_data_q;
        if (rd_vld_pipe_q[1]) rd_data_d = s2_q.byp ? s2_q.bdata : sram_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            clr_cnt_q     <= '0;
            clr_done_q    <= 1'b0;
            fifo_addr_q   <= '0;
            fifo_data_q   <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            cnt_q         <= '0;
            rd_vld_pipe_q <= '0;
            s1_q          <= '0;
            s2_q          <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            wr_full_q     <= 1'b0;
            wr_drop_q     <= 1'b0;
            sram_addr_q   <= '0;
            sram_we_q     <= 1'b0;
            sram_wdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            clr_done_q    <= clr_done_d;
            fifo_addr_q   <= fifo_addr_d;
            fifo_data_q   <= fifo_data_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            cnt_q         <= cnt_d;
            rd_vld_pipe_q <= rd_vld_pipe_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            wr_full_q     <= wr_full_d;
            wr_drop_q     <= wr_drop_d;
            sram_addr_q   <= sram_addr_d;
            sram_we_q     <= sram_we_d;
            sram_wdata_q  <= sram_wdata_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign wr_full    = wr_full_q;
    assign wr_drop    = wr_drop_q;
    assign clear_busy = (state_q == ST_CLEAR);
    assign sram_addr  = sram_addr_q;
    assign sram_we    = sram_we_q;
    assign sram_wdata = sram_wdata_q;

`ifdef HIST_ARB_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (wr_drop_d && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign stat_drop_cnt = drop_cnt_q;
`else
    assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_history_sram_arbiter.sv
// Randomised scoreboard bench for history_sram_arbiter: a logical-memory model predicts read data,
// drops, full and clear activity; a forked monitor compares them against the DUT each cycle.
module tb_history_sram_arbiter;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;
    localparam int NPIX   = 16;
`ifdef HIST_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk, reset;
    logic              rd_req, wr_req, clear_start;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid, wr_full, wr_drop, clear_busy, sram_we;
    logic [DATA_W-1:0] rd_data, sram_wdata, sram_rdata;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       stat_drop_cnt;

    history_sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .NUM_PIXELS(NPIX)) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_full(wr_full), .wr_drop(wr_drop),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .sram_addr(sram_addr), .sram_we(sram_we), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .stat_drop_cnt(stat_drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM: registered address from the DUT, data returned in the same cycle, write at the edge.
    logic [DATA_W-1:0] mem [64];
    assign sram_rdata = mem[sram_addr[5:0]];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 4'($urandom_range(15));
        mem[5] = 4'hA;
        forever begin
            @(posedge clk);
            if (sram_we) mem[sram_addr[5:0]] <= sram_wdata;
        end
    end

    typedef struct { logic [DATA_W-1:0] d; int cyc; } rexp_t;
    typedef struct { int a; int cyc; } cexp_t;
    rexp_t rq[$];
    cexp_t clrq[$];

    int n_chk = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    // Model: logical memory = what a reader should see (SRAM plus accepted writes).
    logic [DATA_W-1:0] lmem [64];
    int m_cnt, clr_rem, m_drops;
    bit prev_rd, exp_full, exp_drop, exp_busy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; clr_rem = 0; m_drops = 0;
        prev_rd = 0; exp_full = 0; exp_drop = 0; exp_busy = 0;
        for (int i = 0; i < 64; i++) lmem[i] = mem[i];
    endtask

    // One cycle: drive inputs, let the edge happen, update the model with what that edge did.
    task automatic step(input bit rd, input int ra, input bit wr, input int wa,
                        input logic [DATA_W-1:0] wd, input bit cs);
        int c0;
        bit in_clr, pop, drop;
        rexp_t e;
        cexp_t ce;
        c0 = cyc;
        rd_req = rd; rd_addr = ADDR_W'(ra);
        wr_req = wr; wr_addr = ADDR_W'(wa); wr_data = wd;
        clear_start = cs;
        @(posedge clk);
        in_clr = (clr_rem > 0);
        if (rd) begin
            e.d = in_clr ? 4'h0 : lmem[ra];
            e.cyc = c0 + 3;
            rq.push_back(e);
        end
        pop = !in_clr && m_cnt > 0 && !prev_rd;
        drop = 0;
        if (wr) begin
            if (in_clr || (m_cnt == DEPTH && !pop)) drop = 1;
            else begin
                lmem[wa] = wd;
                m_cnt++;
            end
        end
        if (pop) m_cnt--;
        if (in_clr) clr_rem--;
        else if (cs) begin
            clr_rem = NPIX + 1;
            m_cnt = 0;
            for (int a = 0; a < NPIX; a++) begin
                lmem[a] = '0;
                ce.a = a;
                ce.cyc = c0 + 2 + a;
                clrq.push_back(ce);
            end
        end
        prev_rd = rd;
        exp_drop = drop;
        m_drops += int'(drop);
        exp_full = (m_cnt == DEPTH);
        exp_busy = (clr_rem > 0);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'h0, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (m_cnt > 0 && n < 50) begin
            idle(1);
            n++;
        end
        idle(3);
    endtask

    task automatic mem_cmp(input string nm);
        int bad = 0;
        for (int a = 0; a < 32; a++) if (mem[a] !== lmem[a]) bad++;
        chk(nm, bad, 0);
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++)
            step($urandom_range(1), $urandom_range(31), $urandom_range(1), $urandom_range(31),
                 4'($urandom_range(15)), 0);
    endtask

    initial begin
        rexp_t e;
        cexp_t ce;
        bit found;
        reset = 1'b1;
        rd_req = 0; rd_addr = '0; wr_req = 0; wr_addr = '0; wr_data = '0; clear_start = 0;

        fork
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    if (rd_valid) begin
                        if (rq.size() == 0) chk("rd_spurious", rd_valid, 0);
                        else begin
                            e = rq.pop_front();
                            chk("rd_data", rd_data, e.d);
                            chk("rd_latency", cyc, e.cyc);
                        end
                    end else if (rq.size() > 0 && cyc >= rq[0].cyc) begin
                        e = rq.pop_front();
                        chk("rd_missing", rd_valid, 1);
                    end
                    if (clrq.size() > 0 && cyc == clrq[0].cyc) begin
                        ce = clrq.pop_front();
                        chk("clr_we", sram_we, 1);
                        chk("clr_addr", sram_addr, ce.a);
                        chk("clr_wdata", sram_wdata, 0);
                    end
                    chk("wr_full", wr_full, exp_full);
                    chk("wr_drop", wr_drop, exp_drop);
                    chk("clear_busy", clear_busy, exp_busy);
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_wr_full", wr_full, 0);
        chk("rst_wr_drop", wr_drop, 0);
        chk("rst_clear_busy", clear_busy, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_sram_we", sram_we, 0);
        chk("rst_stat", stat_drop_cnt, 0);
        model_reset();
        reset = 1'b0;
        mon_en = 1'b1;

        // Plain read of a preloaded word.
        step(1, 5, 0, 0, 4'h0, 0);
        idle(4);

        // Read-after-write forwarded from the queue, then the write lands in the SRAM.
        step(0, 0, 1, 10, 4'h3, 0);
        step(1, 10, 0, 0, 4'h0, 0);
        drain();
        chk("sram_addr10_after_drain", mem[10], 4'h3);

        // Back-to-back reads starve the queue; fifth write overflows.
        for (int i = 0; i < 8; i++) begin
            step(1, $urandom_range(31), i < 5, $urandom_range(31), 4'($urandom_range(15)), 0);
            if (i == 4) begin
                chk("overflow_drop", wr_drop, 1);
                chk("overflow_full", wr_full, 1);
            end
        end
        drain();
        mem_cmp("mem_after_overflow");

        rand_phase(300);
        drain();
        mem_cmp("mem_after_random");
        chk("stat_mid", stat_drop_cnt, STATS ? 16'(m_drops) : 16'd0);

        // Full clear with reads/writes and a redundant clear_start inside it.
        step(0, 0, 0, 0, 4'h0, 1);
        for (int i = 0; i < NPIX + 1; i++)
            step($urandom_range(1), $urandom_range(31), $urandom_range(1), $urandom_range(31),
                 4'($urandom_range(15)), i == 5);
        idle(3);
        mem_cmp("mem_after_clear");
        rand_phase(100);
        drain();
        mem_cmp("mem_after_clear_random");

        // Reset lands in the middle of a clear sweep.
        step(0, 0, 0, 0, 4'h0, 1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            idle(1);
            if (sram_we && sram_addr == ADDR_W'(6)) found = 1;
        end
        chk("clear_reached_addr6", found, 1);
        #2;
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("midclr_rst_sram_we", sram_we, 0);
        chk("midclr_rst_sram_addr", sram_addr, 0);
        chk("midclr_rst_clear_busy", clear_busy, 0);
        chk("midclr_rst_rd_valid", rd_valid, 0);
        chk("midclr_rst_wr_drop", wr_drop, 0);
        chk("midclr_rst_stat", stat_drop_cnt, 0);
        rq.delete();
        clrq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            chk("post_rst_no_write", sram_we, 0);
        end

        // Exactly three overflow drops for the statistics counter.
        for (int i = 0; i < 7; i++)
            step(1, $urandom_range(31), 1, $urandom_range(31), 4'($urandom_range(15)), 0);
        drain();
        chk("stat_three_drops", stat_drop_cnt, STATS ? 16'd3 : 16'd0);
        mem_cmp("mem_final");
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
